// File: rtl/skew_feeder.sv
// skew_feeder: drains K elements from each of ROWS FIFO lanes and presents
// them to a systolic array's west edge as a diagonal wavefront (row i lags
// row 0 by i cycles). The entire wavefront freezes whenever any active lane's
// FIFO is empty, so the skew between rows is never disturbed.
// Optional build macro: FEEDER_TIMEOUT_EN adds a stall counter that aborts a
// job with a sticky error after TIMEOUT_CYCLES consecutive stalled cycles.
module skew_feeder #(
  parameter int ROWS           = 4,
  parameter int DATA_WIDTH     = 8,
  parameter int LEN_WIDTH      = 8,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       start,
  input  logic [LEN_WIDTH-1:0]       len,
  input  logic [ROWS-1:0]            fifo_empty,
  input  logic [ROWS*DATA_WIDTH-1:0] fifo_data,
  output logic [ROWS-1:0]            fifo_read,
  output logic [ROWS*DATA_WIDTH-1:0] array_data,
  output logic [ROWS-1:0]            array_valid,
  output logic                       busy,
  output logic                       done,
  output logic                       error
);

  // Wide enough to hold K+ROWS-2 for the largest K, so it never wraps.
  localparam int TW = LEN_WIDTH + $clog2(ROWS) + 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_FIN  = 2'd2;

  logic [1:0]           r_state;
  logic [LEN_WIDTH-1:0] r_k;
  logic [TW-1:0]        r_t;
  logic                 r_done;

  logic [ROWS-1:0]      w_active;
  logic                 w_stall;
  logic [TW-1:0]        w_t_last;
  logic                 w_timeout;

  assign w_t_last = TW'(r_k) + TW'(ROWS - 2);

  // Lane i carries an element while i <= t < i+K; only meaningful in RUN.
  always_comb begin
    w_active = '0;
    for (int i = 0; i < ROWS; i++) begin
      w_active[i] = (r_state == S_RUN) && (r_t >= TW'(i)) &&
                    (r_t < TW'(i) + TW'(r_k));
    end
  end

  // One empty active lane freezes every lane so the diagonal stays aligned.
  assign w_stall   = |(w_active & fifo_empty);
  assign fifo_read = w_stall ? '0 : w_active;
  assign busy      = (r_state == S_RUN);
  assign done      = r_done;

`ifdef FEEDER_TIMEOUT_EN
  localparam int SW = $clog2(TIMEOUT_CYCLES + 1);

  logic [SW-1:0] r_stall_cnt;
  logic          r_error;

  assign w_timeout = (r_state == S_RUN) && w_stall &&
                     (int'(r_stall_cnt) + 1 >= TIMEOUT_CYCLES);
  assign error     = r_error;

  // Consecutive-stall counter; any progress cycle resets it.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_stall_cnt <= '0;
    end else if (r_state == S_IDLE && start) begin
      r_stall_cnt <= '0;
    end else if (r_state == S_RUN) begin
      r_stall_cnt <= w_stall ? r_stall_cnt + 1'b1 : '0;
    end
  end

  // Sticky abort flag, cleared only when a new job is accepted.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_error <= 1'b0;
    end else if (r_state == S_IDLE && start) begin
      r_error <= 1'b0;
    end else if (w_timeout) begin
      r_error <= 1'b1;
    end
  end
`else
  logic w_unused;

  assign w_timeout = 1'b0;
  assign error     = 1'b0;
  assign w_unused  = ^TIMEOUT_CYCLES;
`endif

  // Job sequencing: IDLE -> RUN (wavefront) -> FIN (done pulse) -> IDLE.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
      r_k     <= '0;
      r_t     <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            if (len != '0) begin
              r_k     <= len;
              r_t     <= '0;
              r_state <= S_RUN;
            end else begin
              r_state <= S_FIN;
            end
          end
        end
        S_RUN: begin
          if (w_timeout) begin
            r_state <= S_FIN;
          end else if (!w_stall) begin
            if (r_t == w_t_last) begin
              r_state <= S_FIN;
            end else begin
              r_t <= r_t + 1'b1;
            end
          end
        end
        S_FIN:   r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Done is registered so it appears the cycle after FIN.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_done <= 1'b0;
    end else begin
      r_done <= (r_state == S_FIN);
    end
  end

  // Edge register: capture popped heads on progress cycles, hold data on stalls.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      array_data  <= '0;
      array_valid <= '0;
    end else if (r_state == S_RUN && !w_stall) begin
      for (int i = 0; i < ROWS; i++) begin
        array_valid[i] <= w_active[i];
        array_data[i*DATA_WIDTH +: DATA_WIDTH] <=
          w_active[i] ? fifo_data[i*DATA_WIDTH +: DATA_WIDTH] : '0;
      end
    end else begin
      array_valid <= '0;
    end
  end

endmodule

// File: tb/tb_skew_feeder.sv
// Self-checking bench for skew_feeder: bench-side FIFO lanes, a table of
// directed jobs, a reset-mid-job sequence, randomized jobs and (with
// FEEDER_TIMEOUT_EN) a timeout sequence.
module tb_skew_feeder;
  localparam int ROWS = 4;
  localparam int DW   = 8;
  localparam int LW   = 8;

  logic                 clk = 1'b0;
  logic                 reset_n;
  logic                 start;
  logic [LW-1:0]        len;
  logic [ROWS-1:0]      fifo_empty;
  logic [ROWS*DW-1:0]   fifo_data;
  logic [ROWS-1:0]      fifo_read;
  logic [ROWS*DW-1:0]   array_data;
  logic [ROWS-1:0]      array_valid;
  logic                 busy;
  logic                 done;
  logic                 error;

  int checks   = 0;
  int failures = 0;

  logic [DW-1:0] q [ROWS][$];

  typedef struct {
    int k;
    int hold_lane;
    int hold_cyc;
    int repulse_cyc;
    int exp_done;
  } job_t;

  job_t tbl [7];

  skew_feeder #(.ROWS(ROWS), .DATA_WIDTH(DW), .LEN_WIDTH(LW), .TIMEOUT_CYCLES(8)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .len(len),
    .fifo_empty(fifo_empty), .fifo_data(fifo_data), .fifo_read(fifo_read),
    .array_data(array_data), .array_valid(array_valid),
    .busy(busy), .done(done), .error(error)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic drive_fifo();
    for (int i = 0; i < ROWS; i++) begin
      fifo_empty[i] = (q[i].size() == 0);
      fifo_data[i*DW +: DW] = (q[i].size() != 0) ? q[i][0] : '0;
    end
  endtask

  task automatic pop_reads();
    for (int i = 0; i < ROWS; i++)
      if (fifo_read[i] && q[i].size() != 0) void'(q[i].pop_front());
  endtask

  task automatic flush();
    for (int i = 0; i < ROWS; i++) q[i].delete();
  endtask

  // One job: lane hold_lane gets its data only at cycle hold_cyc.
  task automatic run_job(input int k, input int hold_lane, input int hold_cyc,
                         input int repulse_cyc, input int exp_done, input bit rnd);
    logic [DW-1:0] exp_q [ROWS][$];
    logic [DW-1:0] held [$];
    logic [ROWS-1:0] mask;
    logic [DW-1:0] v;
    int steps, done_cnt, done_at, left;
    steps = 0; done_cnt = 0; done_at = -1; left = 0;
    for (int i = 0; i < ROWS; i++) begin
      for (int j = 0; j < k; j++) begin
        v = rnd ? DW'($urandom_range(0, 255)) : DW'(10 * i + j + 1);
        exp_q[i].push_back(v);
        if (i == hold_lane) held.push_back(v);
        else q[i].push_back(v);
      end
    end
    for (int n = 0; n <= exp_done + 2; n++) begin
      @(negedge clk);
      if (hold_lane >= 0 && n == hold_cyc)
        foreach (held[j]) q[hold_lane].push_back(held[j]);
      start = (n == 0) || (n == repulse_cyc);
      len   = (n == 0) ? LW'(k) : LW'(7);
      drive_fifo();
      #1;
      chk("underflow", 64'(fifo_read & fifo_empty), 64'(0));
      if (k == 0) begin
        chk("len0_busy", 64'(busy), 64'(0));
        chk("len0_read", 64'(fifo_read), 64'(0));
      end else if (n == 1) begin
        chk("busy_run", 64'(busy), 64'(1));
        chk("error_clear", 64'(error), 64'(0));
      end
      if (array_valid != '0) begin
        for (int i = 0; i < ROWS; i++) mask[i] = (steps >= i) && (steps < i + k);
        chk("valid_mask", 64'(array_valid), 64'(mask));
        for (int i = 0; i < ROWS; i++) begin
          if (array_valid[i]) begin
            if (exp_q[i].size() != 0) chk("lane_data", 64'(array_data[i*DW +: DW]), 64'(exp_q[i].pop_front()));
            else chk("extra_data", 64'(1), 64'(0));
          end
        end
        steps++;
      end
      if (done) begin
        done_cnt++;
        done_at = n;
      end
      pop_reads();
    end
    start = 1'b0;
    for (int i = 0; i < ROWS; i++) left += q[i].size() + exp_q[i].size();
    chk("done_count", 64'(done_cnt), 64'(1));
    chk("done_cycle", 64'(done_at), 64'(exp_done));
    chk("wave_steps", 64'(steps), 64'((k == 0) ? 0 : k + ROWS - 1));
    chk("leftover", 64'(left), 64'(0));
    flush();
  endtask

  initial begin
    int k, hl, hc, stalls;
    tbl[0] = '{3, -1, 0, -1, 8};
    tbl[1] = '{3,  2, 6, -1, 11};
    tbl[2] = '{0, -1, 0, -1, 2};
    tbl[3] = '{3, -1, 0,  2, 8};
    tbl[4] = '{1, -1, 0, -1, 6};
    tbl[5] = '{5,  3, 9, -1, 15};
    tbl[6] = '{2,  0, 3, -1, 9};

    reset_n = 1'b0; start = 1'b0; len = '0;
    drive_fifo();
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_valid", 64'(array_valid), 64'(0));
    chk("rst_data", 64'(array_data), 64'(0));
    chk("rst_ctrl", 64'({busy, done, error}), 64'(0));
    chk("rst_read", 64'(fifo_read), 64'(0));
    reset_n = 1'b1;

    for (int r = 0; r < 7; r++)
      run_job(tbl[r].k, tbl[r].hold_lane, tbl[r].hold_cyc, tbl[r].repulse_cyc, tbl[r].exp_done, 1'b0);

    // Reset asserted while the wavefront is at t=3.
    for (int i = 0; i < ROWS; i++)
      for (int j = 0; j < 3; j++) q[i].push_back(DW'(10 * i + j + 1));
    for (int n = 0; n < 4; n++) begin
      @(negedge clk);
      start = (n == 0); len = LW'(3);
      drive_fifo(); #1;
      pop_reads();
    end
    @(negedge clk);
    start = 1'b0; reset_n = 1'b0; #1;
    chk("midrst_valid", 64'(array_valid), 64'(0));
    chk("midrst_data", 64'(array_data), 64'(0));
    chk("midrst_ctrl", 64'({busy, done, error, fifo_read}), 64'(0));
    for (int i = 0; i < ROWS; i++) chk("midrst_remain", 64'(q[i].size()), 64'(i));
    @(negedge clk);
    reset_n = 1'b1;
    flush();
    run_job(3, -1, 0, -1, 8, 1'b0);

    // Random jobs with an optional late lane.
    for (int r = 0; r < 20; r++) begin
      k  = $urandom_range(1, 6);
      hl = ($urandom_range(0, 2) == 0) ? -1 : $urandom_range(0, ROWS - 1);
      hc = $urandom_range(0, 9);
      stalls = (hl >= 0 && hc > hl + 1) ? hc - hl - 1 : 0;
      run_job(k, hl, hc, -1, k + ROWS + 1 + stalls, 1'b1);
    end

`ifdef FEEDER_TIMEOUT_EN
    begin
      int done_at;
      done_at = -1;
      for (int i = 0; i < ROWS; i++)
        if (i != 1) for (int j = 0; j < 3; j++) q[i].push_back(DW'(j));
      for (int n = 0; n < 15; n++) begin
        @(negedge clk);
        start = (n == 0); len = LW'(3);
        drive_fifo(); #1;
        chk("to_underflow", 64'(fifo_read & fifo_empty), 64'(0));
        if (done) done_at = n;
        pop_reads();
      end
      start = 1'b0;
      chk("to_done_cycle", 64'(done_at), 64'(11));
      chk("to_error", 64'(error), 64'(1));
      flush();
      run_job(1, -1, 0, -1, 6, 1'b0);
    end
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
